// File: rtl/lcd_write_sequencer_pkg.sv
// Shared types and constants for the HD44780 4-bit write sequencer.
// Holds the FSM state enums, the init command bytes and the code-field bit positions.
package lcd_write_sequencer_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        IDLE,
        SET_ADDR_HI,
        SET_ADDR_LO,
        WR_HI,
        WR_LO
    } seq_state_t;

    typedef enum logic [1:0] {
        N_IDLE,
        N_SETUP,
        N_PULSE,
        N_WAIT
    } nib_phase_t;

    localparam logic [7:0] CMD_FUNC_SET   = 8'h28;
    localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
    localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
    localparam logic [7:0] CMD_CLEAR      = 8'h01;
    localparam logic [7:0] CMD_SET_DDRAM  = 8'h80;

    localparam int CODE_RS_BIT = 5;
    localparam int CODE_RW_BIT = 4;

    localparam logic [3:0] INIT_LAST_IDX = 4'd11;

    // Four wake-up nibbles (3,3,3,2), then each init command high nibble first.
    function automatic logic [3:0] init_nibble(input logic [3:0] idx);
        logic [3:0] n;
        case (idx)
            4'd0, 4'd1, 4'd2: n = 4'h3;
            4'd3:             n = 4'h2;
            4'd4:             n = CMD_FUNC_SET[7:4];
            4'd5:             n = CMD_FUNC_SET[3:0];
            4'd6:             n = CMD_DISP_ON[7:4];
            4'd7:             n = CMD_DISP_ON[3:0];
            4'd8:             n = CMD_ENTRY_MODE[7:4];
            4'd9:             n = CMD_ENTRY_MODE[3:0];
            4'd10:            n = CMD_CLEAR[7:4];
            4'd11:            n = CMD_CLEAR[3:0];
            default:          n = 4'h0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lcd_write_sequencer_nibble_writer.sv
// Drives one nibble onto the LCD bus: setup cycle, E pulse, then a post-E wait.
// ready also rises in the last wait cycle so the sequencer can advance without a bubble.
module lcd_nibble_writer
    import lcd_write_sequencer_pkg::*;
#(
    parameter int E_PULSE_CYC = 12,
    parameter int CW          = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          rs_in,
    input  logic [3:0]    nibble,
    input  logic [CW-1:0] wait_cyc,
    output logic          e,
    output logic [3:0]    d,
    output logic          rs,
    output logic          ready
);

    nib_phase_t    phase;
    logic [CW-1:0] cnt;
    logic [CW-1:0] wait_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= N_IDLE;
            cnt    <= '0;
            wait_q <= '0;
            d      <= 4'h0;
            rs     <= 1'b0;
        end else if (ready && start) begin
            phase  <= N_SETUP;
            cnt    <= '0;
            wait_q <= wait_cyc;
            d      <= nibble;
            rs     <= rs_in;
        end else begin
            case (phase)
                N_SETUP: begin
                    phase <= N_PULSE;
                    cnt   <= CW'(E_PULSE_CYC - 1);
                end
                N_PULSE: begin
                    if (cnt == '0) begin
                        phase <= N_WAIT;
                        cnt   <= wait_q - 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                N_WAIT: begin
                    if (cnt == '0) phase <= N_IDLE;
                    else           cnt   <= cnt - 1'b1;
                end
                default: phase <= N_IDLE;
            endcase
        end
    end

    assign e     = (phase == N_PULSE);
    assign ready = (phase == N_IDLE) || ((phase == N_WAIT) && (cnt == '0));

endmodule

// File: rtl/lcd_write_sequencer.sv
// Two-requester HD44780 write sequencer: power-on init, then round-robin
// granted transactions of DDRAM address set followed by one character code pair.
//
// state       | meaning
// PWR_WAIT    | power-on delay before any bus activity
// INIT        | 4-bit wake-up nibbles and init commands
// IDLE        | arbitrate requests
// SET_ADDR_HI | DDRAM address command, high nibble
// SET_ADDR_LO | DDRAM address command, low nibble
// WR_HI       | character code high nibble
// WR_LO       | character code low nibble
module lcd_write_sequencer
    import lcd_write_sequencer_pkg::*;
#(
    parameter int INIT_WAIT_CYC  = 750000,
    parameter int E_PULSE_CYC    = 12,
    parameter int CMD_WAIT_CYC   = 2000,
    parameter int CLEAR_WAIT_CYC = 82000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [6:0] addr0,
    input  logic [6:0] addr1,
    input  logic [5:0] code0_hi,
    input  logic [5:0] code0_lo,
    input  logic [5:0] code1_hi,
    input  logic [5:0] code1_lo,
    output logic [1:0] gnt,
    output logic       done,
    output logic       busy,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [3:0] lcd_d
);

    localparam int MAX_WAIT = (INIT_WAIT_CYC > CLEAR_WAIT_CYC) ? INIT_WAIT_CYC : CLEAR_WAIT_CYC;
    localparam int MAX_CYC  = (MAX_WAIT > E_PULSE_CYC) ? MAX_WAIT : E_PULSE_CYC;
    localparam int CW       = $clog2(MAX_CYC + 1);

    seq_state_t    state, state_nx;
    logic [CW-1:0] pwr_cnt;
    logic [3:0]    init_idx;
    logic          started;
    logic          prio;
    logic [6:0]    addr_q;
    logic [4:0]    hi_q, lo_q;
    logic [1:0]    gnt_pick;
    logic [7:0]    ddram;
    logic          pwr_end, nib_fin, sending;
    logic          nib_start, nib_rs, nib_ready;
    logic [3:0]    nib_d;
    logic [CW-1:0] nib_wait;
    logic          rw_unused;

    // The RW field of incoming codes is intentionally dropped; the bus is write-only.
    assign rw_unused = ^{code0_hi[CODE_RW_BIT], code0_lo[CODE_RW_BIT],
                         code1_hi[CODE_RW_BIT], code1_lo[CODE_RW_BIT]};

    assign pwr_end  = (pwr_cnt == CW'(INIT_WAIT_CYC - 1));
    assign nib_fin  = started & nib_ready;
    assign gnt_pick = (req == 2'b11) ? (prio ? 2'b10 : 2'b01) : req;
    assign ddram    = CMD_SET_DDRAM | {1'b0, addr_q};
    assign busy     = (state != IDLE);
    assign lcd_rw   = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= PWR_WAIT;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            PWR_WAIT:    if (pwr_end) state_nx = INIT;
            INIT:        if (nib_fin && init_idx == INIT_LAST_IDX) state_nx = IDLE;
            IDLE:        if (req != 2'b00) state_nx = SET_ADDR_HI;
            SET_ADDR_HI: if (nib_fin) state_nx = SET_ADDR_LO;
            SET_ADDR_LO: if (nib_fin) state_nx = WR_HI;
            WR_HI:       if (nib_fin) state_nx = WR_LO;
            WR_LO:       if (nib_fin) state_nx = IDLE;
            default:     state_nx = PWR_WAIT;
        endcase
    end

    always_comb begin
        nib_rs   = 1'b0;
        nib_d    = 4'h0;
        nib_wait = CW'(CMD_WAIT_CYC);
        sending  = 1'b1;
        case (state)
            INIT: begin
                nib_d = init_nibble(init_idx);
                if (init_idx == INIT_LAST_IDX) nib_wait = CW'(CLEAR_WAIT_CYC);
            end
            SET_ADDR_HI: nib_d = ddram[7:4];
            SET_ADDR_LO: nib_d = ddram[3:0];
            WR_HI:       {nib_rs, nib_d} = hi_q;
            WR_LO:       {nib_rs, nib_d} = lo_q;
            default:     sending = 1'b0;
        endcase
        nib_start = sending & nib_ready & ~started;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwr_cnt   <= '0;
            init_idx  <= 4'd0;
            started   <= 1'b0;
            prio      <= 1'b0;
            addr_q    <= 7'h00;
            hi_q      <= 5'h00;
            lo_q      <= 5'h00;
            gnt       <= 2'b00;
            done      <= 1'b0;
            init_done <= 1'b0;
        end else begin
            gnt  <= 2'b00;
            done <= (state == WR_LO) && nib_fin;
            if (state == PWR_WAIT && !pwr_end) pwr_cnt <= pwr_cnt + 1'b1;
            if (nib_start)    started <= 1'b1;
            else if (nib_fin) started <= 1'b0;
            if (state == INIT && nib_fin) begin
                init_idx <= init_idx + 4'd1;
                if (init_idx == INIT_LAST_IDX) init_done <= 1'b1;
            end
            if (state == IDLE && req != 2'b00) begin
                gnt  <= gnt_pick;
                prio <= gnt_pick[0];
                if (gnt_pick[1]) begin
                    addr_q <= addr1;
                    hi_q   <= {code1_hi[CODE_RS_BIT], code1_hi[3:0]};
                    lo_q   <= {code1_lo[CODE_RS_BIT], code1_lo[3:0]};
                end else begin
                    addr_q <= addr0;
                    hi_q   <= {code0_hi[CODE_RS_BIT], code0_hi[3:0]};
                    lo_q   <= {code0_lo[CODE_RS_BIT], code0_lo[3:0]};
                end
            end
        end
    end

    lcd_nibble_writer #(
        .E_PULSE_CYC (E_PULSE_CYC),
        .CW          (CW)
    ) u_nibble (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (nib_start),
        .rs_in    (nib_rs),
        .nibble   (nib_d),
        .wait_cyc (nib_wait),
        .e        (lcd_e),
        .d        (lcd_d),
        .rs       (lcd_rs),
        .ready    (nib_ready)
    );

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Bench for lcd_write_sequencer: a bus monitor pops expected {rs,d} nibbles at every E rise.
module tb_lcd_write_sequencer;

    localparam int INIT = 20, EP = 2, CMD = 4, CLR = 8;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [6:0] addr0 = 7'h00, addr1 = 7'h00;
    logic [5:0] code0_hi = 6'h00, code0_lo = 6'h00, code1_hi = 6'h00, code1_lo = 6'h00;
    logic [1:0] gnt;
    logic       done, busy, init_done, lcd_rs, lcd_rw, lcd_e;
    logic [3:0] lcd_d;

    lcd_write_sequencer #(
        .INIT_WAIT_CYC(INIT), .E_PULSE_CYC(EP), .CMD_WAIT_CYC(CMD), .CLEAR_WAIT_CYC(CLR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .addr0(addr0), .addr1(addr1),
        .code0_hi(code0_hi), .code0_lo(code0_lo), .code1_hi(code1_hi), .code1_lo(code1_lo),
        .gnt(gnt), .done(done), .busy(busy), .init_done(init_done),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_d(lcd_d)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0;
    int e_hi = 0, width_bad = 0, rw_bad = 0, last_fall = 0, id_rise = 0, first_gnt = -1, done_cnt = 0;
    logic       e_prev = 1'b0, id_prev = 1'b0;
    logic [4:0] exp_q[$];
    logic [4:0] exp_head;
    logic [1:0] gnt_log[$];
    logic [3:0] init_d [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h6, 4'h0, 4'h1};

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (lcd_e === 1'b1) e_hi++;
        if (lcd_e === 1'b1 && e_prev !== 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL nibble: unexpected rs=%0b d=%h, none required", lcd_rs, lcd_d);
            end else begin
                exp_head = exp_q.pop_front();
                if ({lcd_rs, lcd_d} !== exp_head) begin
                    errors++;
                    $display("FAIL nibble: got rs=%0b d=%h, required rs=%0b d=%h",
                             lcd_rs, lcd_d, exp_head[4], exp_head[3:0]);
                end
            end
        end
        if (lcd_e !== 1'b1 && e_prev === 1'b1) begin
            if (e_hi != EP) width_bad++;
            e_hi = 0;
            last_fall = cyc;
        end
        if (lcd_rw !== 1'b0) rw_bad++;
        if (gnt !== 2'b00) begin
            gnt_log.push_back(gnt);
            if (first_gnt < 0) first_gnt = cyc;
        end
        if (done === 1'b1) done_cnt++;
        if (init_done === 1'b1 && id_prev !== 1'b1) id_rise = cyc;
        e_prev  = lcd_e;
        id_prev = init_done;
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic clear_monitor;
        exp_q.delete();
        gnt_log.delete();
        first_gnt = -1;
        done_cnt  = 0;
        width_bad = 0;
        e_hi      = 0;
    endtask

    task automatic push_init;
        for (int i = 0; i < 12; i++) exp_q.push_back({1'b0, init_d[i]});
    endtask

    task automatic push_txn(input logic [6:0] a, input logic [5:0] ch, input logic [5:0] cl);
        logic [7:0] cmd;
        cmd = 8'h80 | {1'b0, a};
        exp_q.push_back({1'b0, cmd[7:4]});
        exp_q.push_back({1'b0, cmd[3:0]});
        exp_q.push_back({ch[5], ch[3:0]});
        exp_q.push_back({cl[5], cl[3:0]});
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req   = 2'b00;
        repeat (3) tick();
        clear_monitor();
        push_init();
        rst_n = 1'b1;
    endtask

    task automatic wait_init(output bit to);
        int n = 0;
        while (init_done !== 1'b1 && n < 1000) begin tick(); n++; end
        to = (init_done !== 1'b1);
    endtask

    task automatic wait_gnt(input int cnt, output bit to);
        int n = 0;
        while (gnt_log.size() < cnt && n < 1000) begin tick(); n++; end
        to = (gnt_log.size() < cnt);
    endtask

    task automatic wait_done(input int cnt, output bit to);
        int n = 0;
        while (done_cnt < cnt && n < 1000) begin tick(); n++; end
        to = (done_cnt < cnt);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) tick();
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL reset_busy: got %b, required 1", busy); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b, required 0", init_done); end
        checks++; if (gnt !== 2'b00)      begin errors++; $display("FAIL reset_gnt: got %b, required 00", gnt); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
        checks++; if ({lcd_e, lcd_rs, lcd_rw, lcd_d} !== 7'h00)
            begin errors++; $display("FAIL reset_bus: got e=%b rs=%b rw=%b d=%h, required all 0", lcd_e, lcd_rs, lcd_rw, lcd_d); end
    endtask

    task automatic test_init;
        bit to;
        do_reset();
        wait_init(to);
        checks++; if (to) begin errors++; $display("FAIL init_timeout: init_done=%b, required 1", init_done); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL init_count: %0d nibbles missing, required 0", exp_q.size()); end
        checks++; if (id_rise - last_fall != 8)
            begin errors++; $display("FAIL init_done_delay: got %0d cycles, required 8", id_rise - last_fall); end
        checks++; if (width_bad != 0) begin errors++; $display("FAIL e_width: %0d bad pulses, required 0", width_bad); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b, required 0", busy); end
    endtask

    task automatic test_single;
        bit to;
        addr0 = 7'h40; code0_hi = 6'h23; code0_lo = 6'h21;
        gnt_log.delete(); done_cnt = 0;
        push_txn(addr0, code0_hi, code0_lo);
        req = 2'b01;
        wait_gnt(1, to);
        req = 2'b00;
        checks++; if (to || gnt_log[0] !== 2'b01)
            begin errors++; $display("FAIL single_gnt: got %b (timeout=%0b), required 01", to ? 2'b00 : gnt_log[0], to); end
        wait_done(1, to);
        repeat (5) tick();
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done: got %0d pulses, required 1", done_cnt); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_nibbles: %0d missing, required 0", exp_q.size()); end
        checks++; if (gnt_log.size() != 1) begin errors++; $display("FAIL single_gnt_count: got %0d, required 1", gnt_log.size()); end
    endtask

    task automatic test_round_robin;
        bit to;
        logic [1:0] want [3] = '{2'b01, 2'b10, 2'b01};
        do_reset();
        wait_init(to);
        addr0 = 7'h05; code0_hi = 6'h2F; code0_lo = 6'h10;
        addr1 = 7'h7F; code1_hi = 6'h3A; code1_lo = 6'h25;
        push_txn(addr0, code0_hi, code0_lo);
        push_txn(addr1, code1_hi, code1_lo);
        push_txn(addr0, code0_hi, code0_lo);
        req = 2'b11;
        wait_gnt(3, to);
        req = 2'b00;
        wait_done(3, to);
        repeat (5) tick();
        checks++; if (gnt_log.size() != 3) begin errors++; $display("FAIL rr_count: got %0d grants, required 3", gnt_log.size()); end
        for (int i = 0; i < 3 && i < gnt_log.size(); i++) begin
            checks++;
            if (gnt_log[i] !== want[i]) begin errors++; $display("FAIL rr_order[%0d]: got %b, required %b", i, gnt_log[i], want[i]); end
        end
        checks++; if (done_cnt != 3) begin errors++; $display("FAIL rr_done: got %0d, required 3", done_cnt); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rr_nibbles: %0d missing, required 0", exp_q.size()); end
        checks++; if (rw_bad != 0) begin errors++; $display("FAIL rw_low: %0d cycles with rw=1, required 0", rw_bad); end
    endtask

    task automatic test_req_before_init;
        bit to;
        do_reset();
        addr0 = 7'h12; code0_hi = 6'h24; code0_lo = 6'h27;
        push_txn(addr0, code0_hi, code0_lo);
        req = 2'b01;
        wait_init(to);
        checks++; if (to || gnt_log.size() != 0)
            begin errors++; $display("FAIL early_gnt: got %0d grants before init_done, required 0", gnt_log.size()); end
        wait_gnt(1, to);
        req = 2'b00;
        addr0 = 7'h33; code0_hi = 6'h0F; code0_lo = 6'h0E;
        checks++; if (to || first_gnt - id_rise != 1)
            begin errors++; $display("FAIL first_gnt_delay: got %0d cycles, required 1", first_gnt - id_rise); end
        wait_done(1, to);
        checks++; if (to || exp_q.size() != 0)
            begin errors++; $display("FAIL captured_inputs: %0d nibbles missing, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_write;
        bit to;
        int n = 0;
        addr0 = 7'h01; code0_hi = 6'h25; code0_lo = 6'h26;
        gnt_log.delete(); done_cnt = 0;
        exp_q.push_back(5'h08);
        exp_q.push_back(5'h01);
        exp_q.push_back(5'h15);
        req = 2'b01;
        wait_gnt(1, to);
        req = 2'b00;
        while (!(exp_q.size() == 0 && lcd_e === 1'b1) && n < 1000) begin tick(); n++; end
        checks++; if (lcd_e !== 1'b1) begin errors++; $display("FAIL wr_hi_reach: e=%b, required 1", lcd_e); end
        rst_n = 1'b0;
        #1;
        checks++; if (lcd_e !== 1'b0) begin errors++; $display("FAIL async_e_drop: got %b, required 0", lcd_e); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL async_init_done: got %b, required 0", init_done); end
        tick();
        tick();
        clear_monitor();
        push_init();
        push_txn(addr0, code0_hi, code0_lo);
        req = 2'b01;
        rst_n = 1'b1;
        wait_init(to);
        checks++; if (to || gnt_log.size() != 0)
            begin errors++; $display("FAIL rst_early_gnt: got %0d grants before init_done, required 0", gnt_log.size()); end
        wait_gnt(1, to);
        req = 2'b00;
        checks++; if (to || first_gnt - id_rise != 1)
            begin errors++; $display("FAIL rst_first_gnt_delay: got %0d cycles, required 1", first_gnt - id_rise); end
        wait_done(1, to);
        checks++; if (to || exp_q.size() != 0)
            begin errors++; $display("FAIL rst_sequence: %0d nibbles missing, required 0", exp_q.size()); end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: run did not finish, checks=%0d required completion", checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_init();
        test_single();
        test_round_robin();
        test_req_before_init();
        test_reset_mid_write();
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
